id_ex_hazard_forward: RTL and testbench

ID/EX pipeline register combined with the EX-stage forwarding-select generator and load-use hazard detector. Latches decoded operands and control from ID each cycle. Drives the 2-bit select lines of the two EX operand three-input muxes: 00 = ID/EX register value, 01 = EX/MEM result, 10 = MEM/WB result. Generates the one-cycle load-use stall toward IF/ID and the PC, and keeps a saturating stall counter for performance monitoring.

---
 rtl/id_ex_hazard_forward.sv | 138 +++++++++++++
 tb/tb_id_ex_hazard_forward.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_forward.sv
// ID/EX pipeline register with EX operand forwarding selects, load-use stall
// detection and a saturating stall counter.
module id_ex_hazard_forward #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [N-1:0]     id_rs1_data,
    input  logic [N-1:0]     id_rs2_data,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_reg_write,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_reg_write,
    input  logic [N-1:0]     memwb_data,
    output logic             stall,
    output logic             ex_valid,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic [N-1:0]     ex_rs1_data,
    output logic [N-1:0]     ex_rs2_data,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    logic             ex_valid_q, ex_valid_d;
    logic [4:0]       ex_rs1_q, ex_rs1_d;
    logic [4:0]       ex_rs2_q, ex_rs2_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             ex_mem_read_q, ex_mem_read_d;
    logic [N-1:0]     ex_rs1_data_q, ex_rs1_data_d;
    logic [N-1:0]     ex_rs2_data_q, ex_rs2_data_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic hit_rs1, hit_rs2, byp_rs1, byp_rs2;

    always_comb begin
        hit_rs1 = id_uses_rs1 && (id_rs1 == ex_rd_q);
        hit_rs2 = id_uses_rs2 && (id_rs2 == ex_rd_q);
        stall   = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != 5'd0)
                  && (hit_rs1 || hit_rs2);
        // Same-cycle register-file write/read: take the value being written back.
        byp_rs1 = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs1);
        byp_rs2 = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == id_rs2);
    end

    always_comb begin
        ex_valid_d     = id_valid;
        ex_rs1_d       = id_rs1;
        ex_rs2_d       = id_rs2;
        ex_rd_d        = id_rd;
        ex_reg_write_d = id_reg_write && id_valid;
        ex_mem_read_d  = id_mem_read && id_valid;
        ex_rs1_data_d  = byp_rs1 ? memwb_data : id_rs1_data;
        ex_rs2_data_d  = byp_rs2 ? memwb_data : id_rs2_data;
        if (flush || stall) begin
            ex_valid_d     = 1'b0;
            ex_rs1_d       = 5'd0;
            ex_rs2_d       = 5'd0;
            ex_rd_d        = 5'd0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_rs1_data_d  = '0;
            ex_rs2_data_d  = '0;
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_q       <= 5'd0;
            ex_rs2_q       <= 5'd0;
            ex_rd_q        <= 5'd0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            stall_count_q  <= stall_count_d;
        end
    end

    // EX/MEM wins over MEM/WB because it carries the younger result.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_valid_q) begin
            if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs1_q)) begin
                fwd_a_sel = 2'b01;
            end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs1_q)) begin
                fwd_a_sel = 2'b10;
            end
            if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs2_q)) begin
                fwd_b_sel = 2'b01;
            end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs2_q)) begin
                fwd_b_sel = 2'b10;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_rs1       = ex_rs1_q;
    assign ex_rs2       = ex_rs2_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_rs1_data  = ex_rs1_data_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_hazard_forward.sv
// Self-checking bench for id_ex_hazard_forward: directed hazard/forwarding
// scenarios plus randomized traffic compared against an instruction-level model.
module tb_id_ex_hazard_forward;
    localparam int N     = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk, rst_n, flush, id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
    logic id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
    logic [N-1:0] id_rs1_data, id_rs2_data, memwb_data;
    logic exmem_reg_write, memwb_reg_write;
    logic stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [N-1:0] ex_rs1_data, ex_rs2_data;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    int tests_run = 0;
    int tests_failed = 0;

    id_ex_hazard_forward #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model: the instruction sitting in EX ----------------
    typedef struct {
        bit          valid;
        bit          is_load;
        bit          writes;
        int          rs1, rs2, rd;
        logic [N-1:0] d1, d2;
    } instr_t;

    instr_t m_ex;
    int     m_cnt;

    function automatic bit exp_stall();
        bit reads_rd;
        reads_rd = (id_uses_rs1 && int'(id_rs1) == m_ex.rd) ||
                   (id_uses_rs2 && int'(id_rs2) == m_ex.rd);
        return id_valid && m_ex.valid && m_ex.is_load && m_ex.rd != 0 && reads_rd;
    endfunction

    function automatic logic [1:0] exp_sel(input int src);
        if (!m_ex.valid || src == 0) return 2'd0;
        if (exmem_reg_write && int'(exmem_rd) == src) return 2'd1;
        if (memwb_reg_write && int'(memwb_rd) == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [N-1:0] reg_read(input int r, input logic [N-1:0] rf_val);
        if (memwb_reg_write && r != 0 && int'(memwb_rd) == r) return memwb_data;
        return rf_val;
    endfunction

    function automatic logic [85:0] exp_regs();
        return {m_ex.valid, 5'(m_ex.rs1), 5'(m_ex.rs2), 5'(m_ex.rd), m_ex.writes,
                m_ex.is_load, m_ex.d1, m_ex.d2, CNT_W'(m_cnt)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        bit s;
        instr_t nxt;
        s = exp_stall();
        nxt.valid = 0; nxt.is_load = 0; nxt.writes = 0;
        nxt.rs1 = 0; nxt.rs2 = 0; nxt.rd = 0; nxt.d1 = '0; nxt.d2 = '0;
        @(posedge clk);
        if (!rst_n) begin
            m_ex = nxt;
            m_cnt = 0;
        end else begin
            if (s && m_cnt < CNT_MAX) m_cnt++;
            if (!(flush || s)) begin
                nxt.valid = id_valid;
                nxt.is_load = id_valid && id_mem_read;
                nxt.writes = id_valid && id_reg_write;
                nxt.rs1 = id_rs1; nxt.rs2 = id_rs2; nxt.rd = id_rd;
                nxt.d1 = reg_read(id_rs1, id_rs1_data);
                nxt.d2 = reg_read(id_rs2, id_rs2_data);
            end
            m_ex = nxt;
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst_n = 1; flush = 0; id_valid = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_reg_write = 0; id_mem_read = 0; id_rs1_data = '0; id_rs2_data = '0;
        exmem_rd = 0; exmem_reg_write = 0; memwb_rd = 0; memwb_reg_write = 0; memwb_data = '0;
    endtask

    task automatic set_id(input bit v, input int r1, input int r2, input int rd,
                          input bit u1, input bit u2, input bit rw, input bit mr,
                          input logic [N-1:0] d1, input logic [N-1:0] d2);
        id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
        id_rs1_data = d1; id_rs2_data = d2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_idle();
        set_id(1, 7, 7, 7, 1, 1, 1, 1, 32'hFFFF_0001, 32'hFFFF_0002);
        exmem_rd = 7; exmem_reg_write = 1; memwb_rd = 7; memwb_reg_write = 1;
        memwb_data = 32'h1234_5678; flush = 1; rst_n = 0;
        step(); step();
        #1;
        tests_run++; if ({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_rs1_data, ex_rs2_data} !== '0) begin tests_failed++; $display("FAIL reset_regs: got %h %h %h %0d %0d %0d want all zero", ex_valid, ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd); end
        tests_run++; if (stall_count !== 0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", stall_count); end
        tests_run++; if ({stall, fwd_a_sel, fwd_b_sel} !== 5'b0) begin tests_failed++; $display("FAIL reset_comb: got stall=%b a=%b b=%b want 0", stall, fwd_a_sel, fwd_b_sel); end
        set_idle();
        set_id(1, 1, 2, 3, 1, 1, 1, 0, 32'h0000_A5A5, 32'h0000_5A5A);
        #1;
        tests_run++; if (ex_valid !== 1'b0) begin tests_failed++; $display("FAIL release_early: got ex_valid=%b want 0", ex_valid); end
        step(); #1;
        tests_run++; if ({ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_rs1_data} !== {1'b1, 5'd3, 1'b1, 1'b0, 32'h0000_A5A5}) begin tests_failed++; $display("FAIL release_first: got v=%b rd=%0d rw=%b mr=%b d1=%h want 1 3 1 0 a5a5", ex_valid, ex_rd, ex_reg_write, ex_mem_read, ex_rs1_data); end
    endtask

    task automatic test_forward();
        set_idle();
        set_id(1, 5, 6, 9, 1, 1, 1, 0, 32'h1, 32'h2);
        step();
        set_idle();
        exmem_rd = 5; exmem_reg_write = 1; memwb_rd = 5; memwb_reg_write = 1; #1;
        tests_run++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin tests_failed++; $display("FAIL fwd_exmem_prio: got a=%b b=%b want 01 00", fwd_a_sel, fwd_b_sel); end
        exmem_reg_write = 0; #1;
        tests_run++; if (fwd_a_sel !== 2'b10) begin tests_failed++; $display("FAIL fwd_memwb: got a=%b want 10", fwd_a_sel); end
        exmem_rd = 6; exmem_reg_write = 1; memwb_rd = 6; #1;
        tests_run++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin tests_failed++; $display("FAIL fwd_b_exmem: got a=%b b=%b want 00 01", fwd_a_sel, fwd_b_sel); end
        set_id(1, 0, 0, 9, 1, 1, 1, 0, 32'h1, 32'h2);
        step();
        set_idle();
        exmem_rd = 0; exmem_reg_write = 1; memwb_rd = 0; memwb_reg_write = 1; #1;
        tests_run++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin tests_failed++; $display("FAIL fwd_x0: got a=%b b=%b want 00 00", fwd_a_sel, fwd_b_sel); end
    endtask

    task automatic test_load_use();
        set_idle();
        set_id(1, 1, 2, 7, 1, 1, 1, 1, 32'h10, 32'h20);
        step();
        set_id(1, 1, 7, 8, 1, 1, 1, 0, 32'h30, 32'h40);
        #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL load_use_stall: got %b want 1", stall); end
        step();
        exmem_rd = 7; exmem_reg_write = 1; #1;
        tests_run++; if ({ex_valid, fwd_a_sel, fwd_b_sel, stall} !== 6'b0) begin tests_failed++; $display("FAIL load_use_bubble: got v=%b a=%b b=%b stall=%b want 0", ex_valid, fwd_a_sel, fwd_b_sel, stall); end
        tests_run++; if (stall_count !== 1) begin tests_failed++; $display("FAIL load_use_count: got %0d want 1", stall_count); end
        step();
        exmem_reg_write = 0; memwb_rd = 7; memwb_reg_write = 1; #1;
        tests_run++; if ({stall, ex_valid, ex_rs2, fwd_b_sel} !== {1'b0, 1'b1, 5'd7, 2'b10}) begin tests_failed++; $display("FAIL load_use_resume: got stall=%b v=%b rs2=%0d b=%b want 0 1 7 10", stall, ex_valid, ex_rs2, fwd_b_sel); end
    endtask

    task automatic test_x0_unused();
        set_idle();
        set_id(1, 1, 2, 0, 1, 1, 1, 1, 32'h1, 32'h2);
        step();
        set_id(1, 0, 3, 4, 1, 0, 1, 0, 32'h1, 32'h2); #1;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL x0_no_stall: got %b want 0", stall); end
        set_id(1, 1, 2, 7, 1, 1, 1, 1, 32'h1, 32'h2);
        step();
        set_id(1, 1, 7, 4, 1, 0, 1, 0, 32'h1, 32'h2); #1;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL unused_rs2: got %b want 0", stall); end
        id_uses_rs2 = 1; #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL used_rs2: got %b want 1", stall); end
        step();
    endtask

    task automatic test_write_through();
        set_idle();
        set_id(1, 3, 3, 9, 1, 1, 1, 0, 32'h11, 32'h22);
        memwb_rd = 3; memwb_reg_write = 1; memwb_data = 32'hDEAD_BEEF;
        step(); #1;
        tests_run++; if ({ex_rs1_data, ex_rs2_data} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL write_through: got %h %h want deadbeef deadbeef", ex_rs1_data, ex_rs2_data); end
        memwb_reg_write = 0;
        step(); #1;
        tests_run++; if (ex_rs1_data !== 32'h11) begin tests_failed++; $display("FAIL wt_no_write: got %h want 11", ex_rs1_data); end
        set_id(1, 0, 4, 9, 1, 1, 1, 0, 32'h55, 32'h66);
        memwb_rd = 0; memwb_reg_write = 1;
        step(); #1;
        tests_run++; if (ex_rs1_data !== 32'h55) begin tests_failed++; $display("FAIL wt_x0: got %h want 55", ex_rs1_data); end
    endtask

    task automatic test_flush_stall();
        set_idle();
        set_id(1, 1, 2, 7, 1, 1, 1, 1, 32'h1, 32'h2);
        step();
        set_id(1, 7, 2, 8, 1, 1, 1, 0, 32'h3, 32'h4);
        flush = 1; #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL flush_stall_stall: got %b want 1", stall); end
        step(); #1;
        tests_run++; if ({ex_valid, ex_rd, ex_rs1_data, ex_reg_write} !== '0) begin tests_failed++; $display("FAIL flush_stall_bubble: got v=%b rd=%0d d1=%h rw=%b want 0", ex_valid, ex_rd, ex_rs1_data, ex_reg_write); end
        tests_run++; if (stall_count !== CNT_W'(m_cnt)) begin tests_failed++; $display("FAIL flush_stall_count: got %0d want %0d", stall_count, m_cnt); end
        set_id(1, 1, 2, 5, 1, 1, 1, 0, 32'h9, 32'h8);
        step(); #1;
        tests_run++; if ({ex_valid, ex_rd} !== 6'b0) begin tests_failed++; $display("FAIL flush_only: got v=%b rd=%0d want 0 0", ex_valid, ex_rd); end
        flush = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            flush = ($urandom_range(0, 9) == 0);
            set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom, $urandom);
            exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = $urandom_range(0, 1);
            memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = $urandom_range(0, 1);
            memwb_data = $urandom;
            #1;
            tests_run++; if ({stall, fwd_a_sel, fwd_b_sel} !== {exp_stall(), exp_sel(m_ex.rs1), exp_sel(m_ex.rs2)}) begin tests_failed++; $display("FAIL rand_comb[%0d]: got stall=%b a=%b b=%b want %b %b %b", i, stall, fwd_a_sel, fwd_b_sel, exp_stall(), exp_sel(m_ex.rs1), exp_sel(m_ex.rs2)); end
            tests_run++; if ({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_rs1_data, ex_rs2_data, stall_count} !== exp_regs()) begin tests_failed++; $display("FAIL rand_regs[%0d]: got %h want %h", i, {ex_valid, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read, ex_rs1_data, ex_rs2_data, stall_count}, exp_regs()); end
            step();
        end
    endtask

    task automatic test_saturation();
        set_idle();
        rst_n = 0;
        step();
        rst_n = 1;
        // A load that reads its own destination stalls every other cycle.
        set_id(1, 7, 0, 7, 1, 0, 1, 1, 32'h7, 32'h0);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (i == 20) begin
                tests_run++; if (stall_count !== 10) begin tests_failed++; $display("FAIL sat_mid: got %0d want 10", stall_count); end
            end
            tests_run++; if (stall !== exp_stall()) begin tests_failed++; $display("FAIL sat_stall[%0d]: got %b want %b", i, stall, exp_stall()); end
            step();
        end
        #1;
        tests_run++; if (stall_count !== 4'd15) begin tests_failed++; $display("FAIL sat_count: got %0d want 15", stall_count); end
    endtask

    initial begin
        m_ex.valid = 0; m_ex.is_load = 0; m_ex.writes = 0;
        m_ex.rs1 = 0; m_ex.rs2 = 0; m_ex.rd = 0; m_ex.d1 = '0; m_ex.d2 = '0;
        m_cnt = 0;
        set_idle();
        rst_n = 0;
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_x0_unused();
        test_write_through();
        test_flush_stall();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
